// File: rtl/mem_port_arbiter.sv
// Purpose: shares one fixed-latency memory port between IF fetch and MEM load/store, MEM-first with a fetch starvation guard.
// Latency: gnt 1 cycle after a request is seen in IDLE, rvalid MEM_LAT+1 cycles after gnt; one transaction per MEM_LAT+3 cycles.
// Backpressure: requesters hold req until gnt; the loser waits in place, fetch is deferred at most STARVE_MAX grants.
// Optional feature: define ARB_IF_FLUSH_EN to add if_flush, which squashes the result of an in-flight fetch.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
`ifdef ARB_IF_FLUSH_EN
  input  logic              if_flush,
`endif
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              sel_dm_q, sel_dm_d;   // winner of the current transaction: 1 = MEM stage
  logic [3:0]        starve_q, starve_d;
  logic [3:0]        lat_q, lat_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              win_dm;
  logic              kill_now;             // current fetch must not deliver data

  // State and datapath registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sel_dm_q   <= 1'b0;
      starve_q   <= '0;
      lat_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      sel_dm_q   <= sel_dm_d;
      starve_q   <= starve_d;
      lat_q      <= lat_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Arbitration in IDLE, then a fixed ISSUE -> WAIT(MEM_LAT) -> DONE sequence per transaction.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    sel_dm_d   = sel_dm_q;
    starve_d   = starve_q;
    lat_d      = lat_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    win_dm     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!if_req) starve_d = '0;
        if (dm_req || if_req) begin
          // MEM stage wins unless fetch has already been passed over STARVE_MAX times.
          win_dm   = dm_req && !(if_req && (starve_q == STARVE_LIM));
          sel_dm_d = win_dm;
          state_d  = ISSUE;
          if (win_dm) begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            if (if_req && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            starve_d = '0;
          end
        end
      end
      ISSUE: begin
        lat_d   = LAT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 4'd1) begin
          // This is cycle ISSUE+MEM_LAT: read data is on mem_rdata now.
          lat_d   = '0;
          state_d = DONE;
          if (!we_q) begin
            if (sel_dm_q) dm_rdata_d = mem_rdata;
            else if (!kill_now) if_rdata_d = mem_rdata;
          end
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ARB_IF_FLUSH_EN
  logic kill_q, kill_d;

  // A flush seen anywhere in a fetch's ISSUE/WAIT/DONE squashes that fetch; forgotten back in IDLE.
  always_comb begin
    kill_d = kill_q;
    if (state_q == IDLE) kill_d = 1'b0;
    else if (!sel_dm_q && if_flush) kill_d = 1'b1;
  end

  // Kill flag register.
  always_ff @(posedge clk) begin
    if (rst) kill_q <= 1'b0;
    else     kill_q <= kill_d;
  end

  // Include the live flush so a flush in the capture or DONE cycle itself still takes effect.
  assign kill_now = kill_q || if_flush;
`else
  assign kill_now = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = (state_q == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_gnt    = (state_q == ISSUE) && !sel_dm_q;
  assign dm_gnt    = (state_q == ISSUE) && sel_dm_q;
  assign if_rvalid = (state_q == DONE) && !sel_dm_q && !kill_now;
  assign dm_rvalid = (state_q == DONE) && sel_dm_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a transaction-timeline model and a fixed-latency memory.
// Inputs change 1 time unit after posedge; the model advances on posedge; outputs are compared on negedge.
// Define ARB_IF_FLUSH_EN for both files to exercise the fetch-flush feature.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
`ifdef ARB_IF_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_flush;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt, dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
`ifdef ARB_IF_FLUSH_EN
    .if_flush(if_flush),
`endif
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h, required 'h%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory: a read issued in cycle E shows its word only during cycle E+MEM_LAT, junk otherwise.
  int                rd_cyc = -1;
  logic [DATA_W-1:0] rd_dat = '0;
  always @(posedge clk) begin
    #1;
    if (cyc == rd_cyc) mem_rdata = rd_dat;
    else               mem_rdata = 32'hBAD0_0000 ^ cyc;
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else begin
        rd_cyc = cyc + MEM_LAT;
        rd_dat = mem[mem_addr];
      end
    end
  end

  // Model: each transaction is a timeline anchored at its issue cycle E.
  bit                m_active = 1'b0, m_dm = 1'b0, m_we = 1'b0, m_kill = 1'b0;
  int                m_E = 0, m_starve = 0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_dm = 1'b0; m_we = 1'b0; m_kill = 1'b0;
      m_starve = 0; m_addr = '0; m_wdata = '0;
      m_if_rdata = '0; m_dm_rdata = '0;
      chk_en = 1'b1;
    end else if (m_active) begin
      if (!m_dm && FLUSH_EN && if_flush) m_kill = 1'b1;
      if (cyc == m_E + MEM_LAT && !m_we) begin
        if (m_dm) m_dm_rdata = mem[m_addr];
        else if (!m_kill) m_if_rdata = mem[m_addr];
      end
      if (cyc == m_E + MEM_LAT + 1) m_active = 1'b0;
    end else begin
      if (!if_req) m_starve = 0;
      if (if_req || dm_req) begin
        m_dm = dm_req && !(if_req && m_starve == STARVE_MAX);
        if (m_dm) begin
          if (if_req && m_starve < STARVE_MAX) m_starve++;
          m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
        end else begin
          m_starve = 0; m_we = 1'b0; m_addr = if_addr;
        end
        m_active = 1'b1; m_E = cyc + 1; m_kill = 1'b0;
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    bit iss, don, kil;
    if (chk_en) begin
      iss = m_active && (cyc == m_E);
      don = m_active && (cyc == m_E + MEM_LAT + 1);
      kil = m_kill || (FLUSH_EN && if_flush);
      chk("busy",      32'(busy),      32'(m_active));
      chk("mem_en",    32'(mem_en),    32'(iss));
      chk("mem_we",    32'(mem_we),    32'(iss && m_we));
      chk("if_gnt",    32'(if_gnt),    32'(iss && !m_dm));
      chk("dm_gnt",    32'(dm_gnt),    32'(iss && m_dm));
      chk("if_rvalid", 32'(if_rvalid), 32'(don && !m_dm && !kil));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(don && m_dm));
      chk("if_rdata",  if_rdata,       m_if_rdata);
      chk("dm_rdata",  dm_rdata,       m_dm_rdata);
      if (iss) begin
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Directed sequences with literal expectations (cycle numbers relative to each request).
  initial begin
    logic [5:0] order;
    int         n, cnt;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'hA500_0000 | i;
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_flush = 1'b0;
    if_addr = 10'd1; dm_we = 1'b0; dm_addr = 10'd2; dm_wdata = 32'h0;

    // Reset held 3 cycles with both requests up.
    repeat (3) step();
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_addr",   32'(mem_addr), 32'd0);
    chk("rst_wdata",  mem_wdata,   32'd0);
    chk("rst_if_rd",  if_rdata,    32'd0);
    chk("rst_dm_rd",  dm_rdata,    32'd0);
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    repeat (2) step();

    // Fetch from address 5.
    mem[5] = 32'hDEADBEEF; if_req = 1'b1; if_addr = 10'd5;
    step();
    chk("fetch_gnt",   32'(if_gnt),   32'd1);
    chk("fetch_en",    32'(mem_en),   32'd1);
    chk("fetch_addr",  32'(mem_addr), 32'd5);
    chk("fetch_we",    32'(mem_we),   32'd0);
    if_req = 1'b0; if_addr = 10'd9;
    repeat (3) step();
    chk("fetch_rvalid", 32'(if_rvalid), 32'd1);
    chk("fetch_rdata",  if_rdata,       32'hDEADBEEF);
    step();

    // Contention: MEM load wins, fetch follows after the load completes.
    mem[10'h20] = 32'hCAFEF00D; mem[6] = 32'h0606_0606;
    if_req = 1'b1; if_addr = 10'd6; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h20;
    step();
    chk("cont_dm_gnt", 32'(dm_gnt), 32'd1);
    chk("cont_if_gnt", 32'(if_gnt), 32'd0);
    dm_req = 1'b0;
    repeat (3) step();
    chk("cont_dm_rvalid", 32'(dm_rvalid), 32'd1);
    chk("cont_dm_rdata",  dm_rdata,       32'hCAFEF00D);
    repeat (2) step();
    chk("cont_if_gnt6", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    repeat (3) step();
    chk("cont_if_rdata", if_rdata, 32'h0606_0606);
    step();

    // Store: address/data change after gnt must not matter; dm_rdata keeps the last load.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h10; dm_wdata = 32'h12345678;
    step();
    chk("st_gnt",   32'(dm_gnt),   32'd1);
    chk("st_we",    32'(mem_we),   32'd1);
    chk("st_addr",  32'(mem_addr), 32'h10);
    chk("st_wdata", mem_wdata,     32'h12345678);
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 10'h3FF; dm_wdata = 32'hFFFF_FFFF;
    repeat (3) step();
    chk("st_rvalid", 32'(dm_rvalid), 32'd1);
    chk("st_rdata",  dm_rdata,       32'hCAFEF00D);
    chk("st_mem",    mem[10'h10],    32'h12345678);
    step();

    // Starvation guard: both requests held, grant order dm,dm,dm,dm,if,dm.
    if_req = 1'b1; if_addr = 10'd3; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h10;
    order = '0; n = 0;
    for (int k = 0; k < 80 && n < 6; k++) begin
      step();
      if (dm_gnt) begin order[n] = 1'b1; n++; end
      else if (if_gnt) begin order[n] = 1'b0; n++; end
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("starve_count", 32'(n),     32'd6);
    chk("starve_order", 32'(order), 32'b101111);
    repeat (5) step();

    // Withdraw: a fetch request dropped before any grant leaves no trace.
    dm_req = 1'b1; dm_addr = 10'h20;
    step();
    dm_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 10'd4;
    step();
    if_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (if_gnt) cnt++;
    end
    chk("withdraw_if_gnt", 32'(cnt), 32'd0);

    // Reset in the middle of a fetch's WAIT.
    mem[7] = 32'h7777_7777; if_req = 1'b1; if_addr = 10'd7;
    step();
    if_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy",  32'(busy),     32'd0);
    chk("mid_rst_rdata", if_rdata,      32'd0);
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      if (if_rvalid) cnt++;
      step();
    end
    chk("mid_rst_rvalid", 32'(cnt), 32'd0);

`ifdef ARB_IF_FLUSH_EN
    // Flush during WAIT: no rvalid, if_rdata keeps the previous fetch's word.
    mem[8] = 32'h1111_2222; if_req = 1'b1; if_addr = 10'd8;
    step();
    if_req = 1'b0;
    repeat (3) step();
    chk("fl_prev_rdata", if_rdata, 32'h1111_2222);
    step();
    mem[9] = 32'h9999_0000; if_req = 1'b1; if_addr = 10'd9;
    step();
    if_req = 1'b0;
    step();
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    step();
    chk("fl_rvalid", 32'(if_rvalid), 32'd0);
    chk("fl_rdata",  if_rdata,       32'h1111_2222);
    step();
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
